// File: rtl/rng_range_sampler.sv
// Draws LFSR samples and maps them uniformly onto 1..N by masked rejection sampling,
// presenting the result over a valid/ack handshake. Define RNG_SAMPLER_STATS_EN to build the reject counter.
module rng_range_sampler #(
  parameter int WIDTH     = 8,
  parameter int MAX_TRIES = 16
) (
  input  logic             clk,
  input  logic             start_n,
  input  logic [WIDTH-1:0] rand_in,
  input  logic [WIDTH-1:0] range,
  input  logic             req,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] value,
  output logic             err,
  output logic [15:0]      reject_cnt
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] sample_m;
  logic             accept;
  logic             last_try;

  // Smallest all-ones pattern covering n-1: bit i is set if any bit at or above i is set.
  function automatic logic [WIDTH-1:0] mask_for(input logic [WIDTH-1:0] n);
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] m;
    x = n - WIDTH'(1);
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = |(x >> i);
    end
    return m;
  endfunction

  assign sample_m = rand_in & mask_q;
  assign accept   = (sample_m < n_q);
  assign last_try = (tries_q == TRY_W'(MAX_TRIES - 1));

  always_ff @(posedge clk or negedge start_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!start_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    n_d     = n_q;
    mask_d  = mask_q;
    tries_d = tries_q;
    value_d = value_q;
    valid_d = valid_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (range != '0) begin
            n_d     = range;
            mask_d  = mask_for(range);
            tries_d = '0;
            state_d = SAMPLE;
          end else begin
            value_d = '0;
            err_d   = 1'b1;
            valid_d = 1'b1;
            state_d = DONE;
          end
        end
      end

      SAMPLE: begin
        if (accept) begin
          // m < N <= 2^WIDTH-1, so m+1 always fits in WIDTH bits.
          value_d = sample_m + WIDTH'(1);
          err_d   = 1'b0;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          tries_d = tries_q + TRY_W'(1);
          if (last_try) begin
            value_d = '0;
            err_d   = 1'b1;
            valid_d = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        // ack takes priority; a req arriving here is dropped, not queued.
        if (ack) begin
          value_d = '0;
          err_d   = 1'b0;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge start_n) begin
    if (!start_n) begin
      n_q     <= '0;
      mask_q  <= '0;
      tries_q <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      n_q     <= n_d;
      mask_q  <= mask_d;
      tries_q <= tries_d;
      value_q <= value_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign busy  = (state_q == SAMPLE);
  assign valid = valid_q;
  assign value = value_q;
  assign err   = err_q;

`ifdef RNG_SAMPLER_STATS_EN
  logic        reject;
  logic [15:0] reject_cnt_q;

  assign reject = (state_q == SAMPLE) && !accept;

  always_ff @(posedge clk or negedge start_n) begin
    if (!start_n) begin
      reject_cnt_q <= '0;
    end else if (reject && (reject_cnt_q != 16'hFFFF)) begin
      reject_cnt_q <= reject_cnt_q + 16'd1;
    end
  end

  assign reject_cnt = reject_cnt_q;
`else
  assign reject_cnt = '0;
`endif

endmodule

// File: tb/tb_rng_range_sampler.sv
// Directed self-checking bench for rng_range_sampler; expected reject counts follow RNG_SAMPLER_STATS_EN.
module tb_rng_range_sampler;

`ifdef RNG_SAMPLER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        start_n = 1'b0;
  logic [7:0]  rand_in = 8'h00;
  logic [7:0]  range = 8'h00;
  logic        req = 1'b0;
  logic        ack = 1'b0;
  logic        busy;
  logic        valid;
  logic [7:0]  value;
  logic        err;
  logic [15:0] reject_cnt;

  int checks = 0;
  int errors = 0;
  int rc = 0;

  rng_range_sampler dut (
    .clk       (clk),
    .start_n   (start_n),
    .rand_in   (rand_in),
    .range     (range),
    .req       (req),
    .ack       (ack),
    .busy      (busy),
    .valid     (valid),
    .value     (value),
    .err       (err),
    .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rc(input string tag);
    check(tag, 32'(reject_cnt), STATS ? rc : 0);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_valid_low", 32'(valid), 0);
    check("ack_value_zero", 32'(value), 0);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_err", 32'(err), 0);
    check("rst_value", 32'(value), 0);
    check("rst_rc", 32'(reject_cnt), 0);
    #10 start_n = 1'b1;
    tick();

    // Single accept: N=6, mask 7, rand 0x03 -> 4
    range = 8'd6; req = 1'b1; rand_in = 8'h03;
    tick();
    req = 1'b0;
    check("acc_busy", 32'(busy), 1);
    check("acc_valid_early", 32'(valid), 0);
    tick();
    check("acc_valid", 32'(valid), 1);
    check("acc_value", 32'(value), 4);
    check("acc_err", 32'(err), 0);
    check("acc_busy_done", 32'(busy), 0);
    for (int i = 0; i < 5; i++) begin
      rand_in = 8'(i * 37);
      tick();
      check("acc_hold_valid", 32'(valid), 1);
      check("acc_hold_value", 32'(value), 4);
    end
    do_ack();

    // Rejections: 0x0E (m=6), 0x0F (m=7), 0x21 (m=1 -> 2)
    range = 8'd6; req = 1'b1;
    tick();
    req = 1'b0; rand_in = 8'h0E;
    tick();
    check("rej1_valid", 32'(valid), 0);
    check("rej1_busy", 32'(busy), 1);
    rand_in = 8'h0F;
    tick();
    check("rej2_valid", 32'(valid), 0);
    rand_in = 8'h21;
    tick();
    rc += 2;
    check("rej_valid", 32'(valid), 1);
    check("rej_value", 32'(value), 2);
    check("rej_err", 32'(err), 0);
    check_rc("rej_rc");
    do_ack();

    // Illegal range 0
    range = 8'd0; req = 1'b1;
    tick();
    req = 1'b0;
    check("ill_busy", 32'(busy), 0);
    check("ill_valid", 32'(valid), 1);
    check("ill_err", 32'(err), 1);
    check("ill_value", 32'(value), 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ill_err_clr", 32'(err), 0);
    check("ill_valid_clr", 32'(valid), 0);

    // Give-up: N=5, mask 7, rand 0x07 rejected every time
    range = 8'd5; rand_in = 8'h07; req = 1'b1;
    tick();
    req = 1'b0;
    repeat (15) tick();
    check("gu_still_busy", 32'(busy), 1);
    check("gu_not_valid", 32'(valid), 0);
    tick();
    rc += 16;
    check("gu_valid", 32'(valid), 1);
    check("gu_err", 32'(err), 1);
    check("gu_value", 32'(value), 0);
    check("gu_busy", 32'(busy), 0);
    check_rc("gu_rc");
    do_ack();

    // N=255: 0xFF rejected, 0xFE -> 255
    range = 8'd255; req = 1'b1;
    tick();
    req = 1'b0; rand_in = 8'hFF;
    tick();
    check("max_rej_valid", 32'(valid), 0);
    rand_in = 8'hFE;
    tick();
    rc += 1;
    check("max_valid", 32'(valid), 1);
    check("max_value", 32'(value), 255);
    check("max_err", 32'(err), 0);
    check_rc("max_rc");

    // req while DONE and ack=0 is ignored
    req = 1'b1; range = 8'd3; rand_in = 8'h00;
    tick();
    check("ign_valid", 32'(valid), 1);
    check("ign_value", 32'(value), 255);
    check("ign_busy", 32'(busy), 0);
    // req and ack together: ack wins, req not captured
    ack = 1'b1;
    tick();
    ack = 1'b0; req = 1'b0;
    check("both_valid", 32'(valid), 0);
    check("both_busy", 32'(busy), 0);
    tick();
    check("both_idle_busy", 32'(busy), 0);
    check("both_idle_valid", 32'(valid), 0);

    // N=1: mask 0, any sample -> 1
    range = 8'd1; rand_in = 8'hA7; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    check("one_valid", 32'(valid), 1);
    check("one_value", 32'(value), 1);
    do_ack();

    // Range change after latch has no effect: N=6 kept, rand 5 -> 6
    range = 8'd6; req = 1'b1;
    tick();
    req = 1'b0; range = 8'd2; rand_in = 8'h05;
    tick();
    check("latch_value", 32'(value), 6);
    check("latch_valid", 32'(valid), 1);
    do_ack();

    // Reset mid-SAMPLE
    range = 8'd5; rand_in = 8'h07; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    rc += 2;
    check("pre_rst_busy", 32'(busy), 1);
    check_rc("pre_rst_rc");
    #2 start_n = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_valid", 32'(valid), 0);
    check("mrst_err", 32'(err), 0);
    check("mrst_value", 32'(value), 0);
    check("mrst_rc", 32'(reject_cnt), 0);
    #1 start_n = 1'b1;
    rc = 0;
    range = 8'd6; rand_in = 8'h03; req = 1'b1;
    tick();
    req = 1'b0;
    check("post_rst_busy", 32'(busy), 1);
    tick();
    check("post_rst_valid", 32'(valid), 1);
    check("post_rst_value", 32'(value), 4);
    check_rc("post_rst_rc");
    do_ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
